// File: rtl/norm_shift_seq_pkg.sv
// Shared types and width helpers for the iterative post-add normalizer.
package norm_shift_seq_pkg;

    localparam int BYTE_W = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        SCAN = ST_SCAN,
        DONE = ST_DONE
    } state_t;

    function automatic int lz_width(input int xlen);
        return $clog2(xlen + 1);
    endfunction

    function automatic int num_bytes(input int xlen);
        return xlen / BYTE_W;
    endfunction

    // Byte down-counter width; a single-byte mantissa still needs one bit.
    function automatic int ctr_width(input int nb);
        return (nb > 1) ? $clog2(nb) : 1;
    endfunction

endpackage

// File: rtl/norm_shift_seq_lz8.sv
// Combinational leading-zero counter for one byte; count is 8 when the byte is zero.
module lz8_count
    import norm_shift_seq_pkg::*;
(
    input  logic [BYTE_W-1:0] byte_i,
    output logic [3:0]        count_o,
    output logic              all_zero_o
);

    // Scanning upward lets the highest set bit overwrite lower hits.
    always_comb begin
        count_o = 4'(BYTE_W);
        for (int i = 0; i < BYTE_W; i++) begin
            if (byte_i[i]) begin
                count_o = 4'(BYTE_W - 1 - i);
            end
        end
    end

    assign all_zero_o = ~|byte_i;

endmodule

// File: rtl/norm_shift_seq.sv
// Iterative normalizer: strips zero bytes one per cycle, then finishes the sub-byte shift.
//   state | meaning
//   IDLE  | ready for an operand
//   SCAN  | working register shifting, one byte step per cycle
//   DONE  | registered result presented until ready_i
module norm_shift_seq
    import norm_shift_seq_pkg::*;
#(
    parameter  int XLEN  = 32,
    parameter  int EXP_W = 10,
    localparam int NB    = num_bytes(XLEN),
    localparam int LZ_W  = lz_width(XLEN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [XLEN-1:0]  mant_i,
    input  logic [EXP_W-1:0] exp_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [XLEN-1:0]  mant_o,
    output logic [EXP_W-1:0] exp_o,
    output logic [LZ_W-1:0]  lz_o,
    output logic             zero_o,
    output logic             uf_o
);

    localparam int CNT_W = ctr_width(NB);
    localparam int CMP_W = EXP_W + LZ_W;

    if ((XLEN % BYTE_W) != 0 || XLEN < BYTE_W) begin : g_bad_xlen
        $error("norm_shift_seq: XLEN must be a nonzero multiple of 8");
    end

    state_t            state_q, state_d;
    logic [XLEN-1:0]   work_q, work_d;
    logic [EXP_W-1:0]  exp_in_q, exp_in_d;
    logic [LZ_W-1:0]   lz_q, lz_d;
    logic [CNT_W-1:0]  bytes_left_q, bytes_left_d;

    logic [XLEN-1:0]   mant_o_q, mant_o_d;
    logic [EXP_W-1:0]  exp_o_q, exp_o_d;
    logic [LZ_W-1:0]   lz_o_q, lz_o_d;
    logic              zero_o_q, zero_o_d;
    logic              uf_o_q, uf_o_d;
    logic              valid_o_q, valid_o_d;

    logic [BYTE_W-1:0] top_byte;
    logic [3:0]        top_lz;
    logic              top_zero;
    logic [LZ_W-1:0]   lz_fin;

    assign top_byte = work_q[XLEN-1 -: BYTE_W];

    lz8_count u_lz8 (
        .byte_i     (top_byte),
        .count_o    (top_lz),
        .all_zero_o (top_zero)
    );

    assign lz_fin = lz_q + LZ_W'(top_lz);

    always_comb begin
        state_d      = state_q;
        work_d       = work_q;
        exp_in_d     = exp_in_q;
        lz_d         = lz_q;
        bytes_left_d = bytes_left_q;
        mant_o_d     = mant_o_q;
        exp_o_d      = exp_o_q;
        lz_o_d       = lz_o_q;
        zero_o_d     = zero_o_q;
        uf_o_d       = uf_o_q;
        valid_o_d    = valid_o_q;

        case (state_q)
            IDLE: begin
                if (valid_i) begin
                    work_d       = mant_i;
                    exp_in_d     = exp_i;
                    lz_d         = '0;
                    bytes_left_d = CNT_W'(NB - 1);
                    state_d      = SCAN;
                end
            end
            SCAN: begin
                // Whole-byte steps stop at the last byte so an all-zero input still terminates.
                if (top_zero && (bytes_left_q != '0)) begin
                    work_d       = work_q << BYTE_W;
                    lz_d         = lz_q + LZ_W'(BYTE_W);
                    bytes_left_d = bytes_left_q - CNT_W'(1);
                end else begin
                    lz_d      = lz_fin;
                    mant_o_d  = top_zero ? '0 : (work_q << top_lz);
                    lz_o_d    = lz_fin;
                    zero_o_d  = top_zero;
                    exp_o_d   = top_zero ? exp_in_q : (exp_in_q - EXP_W'(lz_fin));
                    uf_o_d    = !top_zero && (CMP_W'(lz_fin) >= CMP_W'(exp_in_q));
                    valid_o_d = 1'b1;
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (ready_i) begin
                    valid_o_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: begin
                valid_o_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            work_q       <= '0;
            exp_in_q     <= '0;
            lz_q         <= '0;
            bytes_left_q <= '0;
            mant_o_q     <= '0;
            exp_o_q      <= '0;
            lz_o_q       <= '0;
            zero_o_q     <= 1'b0;
            uf_o_q       <= 1'b0;
            valid_o_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            work_q       <= work_d;
            exp_in_q     <= exp_in_d;
            lz_q         <= lz_d;
            bytes_left_q <= bytes_left_d;
            mant_o_q     <= mant_o_d;
            exp_o_q      <= exp_o_d;
            lz_o_q       <= lz_o_d;
            zero_o_q     <= zero_o_d;
            uf_o_q       <= uf_o_d;
            valid_o_q    <= valid_o_d;
        end
    end

    assign ready_o = (state_q == IDLE);
    assign valid_o = valid_o_q;
    assign mant_o  = mant_o_q;
    assign exp_o   = exp_o_q;
    assign lz_o    = lz_o_q;
    assign zero_o  = zero_o_q;
    assign uf_o    = uf_o_q;

endmodule

// File: tb/tb_norm_shift_seq.sv
// Self-checking bench: arithmetic reference model plus directed literal cases and random operands.
module tb_norm_shift_seq;

    localparam int XLEN  = 32;
    localparam int EXP_W = 10;
    localparam int LZ_W  = 6;

    typedef struct packed {
        logic [XLEN-1:0]  mant;
        logic [EXP_W-1:0] exp;
        logic [LZ_W-1:0]  lz;
        logic             zero;
        logic             uf;
        logic [3:0]       lat;
    } res_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             valid_i = 1'b0;
    logic             ready_i = 1'b0;
    logic [XLEN-1:0]  mant_i = '0;
    logic [EXP_W-1:0] exp_i = '0;
    logic             ready_o, valid_o, zero_o, uf_o;
    logic [XLEN-1:0]  mant_o;
    logic [EXP_W-1:0] exp_o;
    logic [LZ_W-1:0]  lz_o;

    int checks = 0;
    int errors = 0;

    norm_shift_seq #(.XLEN(XLEN), .EXP_W(EXP_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .mant_i  (mant_i),
        .exp_i   (exp_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .mant_o  (mant_o),
        .exp_o   (exp_o),
        .lz_o    (lz_o),
        .zero_o  (zero_o),
        .uf_o    (uf_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Plain arithmetic: position of the highest set bit gives everything else.
    function automatic res_t ref_model(input logic [XLEN-1:0] m, input logic [EXP_W-1:0] e);
        res_t r;
        int   lzv;
        int   zb;
        lzv = XLEN;
        for (int i = 0; i < XLEN; i++) begin
            if (m[i]) lzv = XLEN - 1 - i;
        end
        r.zero = (m == '0);
        r.lz   = LZ_W'(lzv);
        r.mant = r.zero ? '0 : (m << lzv);
        r.exp  = r.zero ? e : EXP_W'(int'(e) - lzv);
        r.uf   = !r.zero && (lzv >= int'(e));
        zb     = lzv / 8;
        if (zb > XLEN / 8 - 1) zb = XLEN / 8 - 1;
        r.lat  = 4'(zb + 1);
        return r;
    endfunction

    logic m_init = 1'b0;
    logic m_busy = 1'b0;
    logic m_valid = 1'b0;
    logic m_fresh = 1'b0;
    int   m_cnt = 0;
    res_t p_res = '0;
    res_t m_out = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_init  <= 1'b1;
            m_busy  <= 1'b0;
            m_valid <= 1'b0;
            m_fresh <= 1'b1;
            m_out   <= '0;
            m_cnt   <= 0;
        end else if (m_valid) begin
            if (ready_i) m_valid <= 1'b0;
        end else if (m_busy) begin
            m_cnt <= m_cnt + 1;
            if (m_cnt + 1 == int'(p_res.lat)) begin
                m_busy  <= 1'b0;
                m_valid <= 1'b1;
                m_fresh <= 1'b0;
                m_out   <= p_res;
            end
        end else if (valid_i) begin
            p_res  <= ref_model(mant_i, exp_i);
            m_busy <= 1'b1;
            m_cnt  <= 0;
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            chk("ready_o", 64'(ready_o), 64'(!m_busy && !m_valid));
            chk("valid_o", 64'(valid_o), 64'(m_valid));
            if (m_valid || m_fresh) begin
                chk("mant_o", 64'(mant_o), 64'(m_out.mant));
                chk("exp_o",  64'(exp_o),  64'(m_out.exp));
                chk("lz_o",   64'(lz_o),   64'(m_out.lz));
                chk("zero_o", 64'(zero_o), 64'(m_out.zero));
                chk("uf_o",   64'(uf_o),   64'(m_out.uf));
            end
        end
    end

    task automatic run_op(input logic [XLEN-1:0] m, input logic [EXP_W-1:0] e,
                          input int hold, output int lat, output res_t o);
        int n;
        n = 0;
        while (!ready_o && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("accept_ready", 64'(ready_o), 64'd1);
        valid_i = 1'b1;
        mant_i  = m;
        exp_i   = e;
        @(posedge clk); #1;
        valid_i = 1'b0;
        mant_i  = $urandom;
        exp_i   = EXP_W'($urandom);
        lat = 0;
        while (!valid_o && lat < 50) begin
            valid_i = 1'($urandom);
            mant_i  = $urandom;
            @(posedge clk); #1;
            lat++;
        end
        chk("valid_timeout", 64'(valid_o), 64'd1);
        o.mant = mant_o;
        o.exp  = exp_o;
        o.lz   = lz_o;
        o.zero = zero_o;
        o.uf   = uf_o;
        o.lat  = 4'(lat);
        for (int i = 0; i < hold; i++) begin
            valid_i = 1'($urandom);
            mant_i  = $urandom;
            exp_i   = EXP_W'($urandom);
            @(posedge clk); #1;
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        @(posedge clk); #1;
        ready_i = 1'b0;
        chk("ready_after_hs", 64'(ready_o), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int   lat;
        res_t o;
        res_t ref_r;
        logic [XLEN-1:0]  rm;
        logic [EXP_W-1:0] re;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_ready", 64'(ready_o), 64'd1);
        chk("rst_valid", 64'(valid_o), 64'd0);
        chk("rst_mant",  64'(mant_o),  64'd0);
        chk("rst_lz",    64'(lz_o),    64'd0);

        run_op(32'h8000_0000, 10'd100, 0, lat, o);
        chk("c1_lat",  64'(lat),    64'd1);
        chk("c1_mant", 64'(o.mant), 64'h8000_0000);
        chk("c1_lz",   64'(o.lz),   64'd0);
        chk("c1_exp",  64'(o.exp),  64'd100);
        chk("c1_zero", 64'(o.zero), 64'd0);
        chk("c1_uf",   64'(o.uf),   64'd0);

        run_op(32'h0000_1234, 10'd100, 5, lat, o);
        chk("c2_lat",  64'(lat),    64'd3);
        chk("c2_mant", 64'(o.mant), 64'h91A0_0000);
        chk("c2_lz",   64'(o.lz),   64'd19);
        chk("c2_exp",  64'(o.exp),  64'd81);
        chk("c2_uf",   64'(o.uf),   64'd0);

        run_op(32'h0, 10'd50, 1, lat, o);
        chk("c3_lat",  64'(lat),    64'd4);
        chk("c3_zero", 64'(o.zero), 64'd1);
        chk("c3_lz",   64'(o.lz),   64'd32);
        chk("c3_mant", 64'(o.mant), 64'd0);
        chk("c3_exp",  64'(o.exp),  64'd50);
        chk("c3_uf",   64'(o.uf),   64'd0);

        run_op(32'h0000_0001, 10'd20, 2, lat, o);
        chk("c4_lat",  64'(lat),    64'd4);
        chk("c4_mant", 64'(o.mant), 64'h8000_0000);
        chk("c4_lz",   64'(o.lz),   64'd31);
        chk("c4_exp",  64'(o.exp),  64'd1013);
        chk("c4_uf",   64'(o.uf),   64'd1);

        // Reset on the second scan cycle of a multi-byte operand.
        valid_i = 1'b1;
        mant_i  = 32'h0000_1234;
        exp_i   = 10'd100;
        @(posedge clk); #1;
        valid_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst_valid", 64'(valid_o), 64'd0);
        chk("mid_rst_ready", 64'(ready_o), 64'd1);
        chk("mid_rst_mant",  64'(mant_o),  64'd0);
        chk("mid_rst_exp",   64'(exp_o),   64'd0);
        chk("mid_rst_lz",    64'(lz_o),    64'd0);
        repeat (6) @(posedge clk);
        #1;
        chk("mid_rst_no_result", 64'(valid_o), 64'd0);

        run_op(32'h8000_0000, 10'd100, 0, lat, o);
        chk("c5_lat",  64'(lat),    64'd1);
        chk("c5_mant", 64'(o.mant), 64'h8000_0000);
        chk("c5_exp",  64'(o.exp),  64'd100);

        for (int k = 0; k < 80; k++) begin
            rm = $urandom;
            rm = rm >> $urandom_range(0, 32);
            re = ($urandom_range(0, 1) == 1) ? EXP_W'($urandom_range(0, 40)) : EXP_W'($urandom);
            ref_r = ref_model(rm, re);
            run_op(rm, re, $urandom_range(0, 3), lat, o);
            chk("rand_lat", 64'(lat), 64'(ref_r.lat));
        end

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/norm_shift_seq.md
Name: norm_shift_seq

Overview:
Iterative post-add normalizer for the MAC datapath. It accepts a raw mantissa and biased exponent, strips leading zero bytes one per cycle, then finishes the sub-byte shift. It emits the left-justified mantissa, the leading-zero count and the adjusted exponent. It consumes leading-zero information, the opposite side of the zero-detect path, and sits between the adder and the rounding stage, with valid/ready on both sides.

Parameters:
XLEN, 32, mantissa width in bits; must be a multiple of 8 and at least 8.
EXP_W, 10, biased exponent width (unsigned).
NB, XLEN/8, derived; number of bytes.
LZ_W, $clog2(XLEN+1), derived; width of the leading-zero count.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  synchronous, active-high reset.
valid_i  input  1  upstream operand valid.
ready_o  output  1  block can accept; high only in IDLE.
mant_i  input  XLEN  raw mantissa.
exp_i  input  EXP_W  biased exponent.
valid_o  output  1  result valid.
ready_i  input  1  downstream accepts the result.
mant_o  output  XLEN  normalized mantissa; MSB is 1 unless zero_o is high.
exp_o  output  EXP_W  exp_i - lz_o, mod 2^EXP_W; equals exp_i when zero_o is high.
lz_o  output  LZ_W  leading-zero count, 0..XLEN.
zero_o  output  1  mant_i was all zeros.
uf_o  output  1  lz_o >= exp_i (unsigned compare) for a nonzero input.

Behaviour:
- Reset: state=IDLE; mant_o, exp_o, lz_o, zero_o, uf_o, valid_o all 0; the byte counter is cleared. ready_o=1 from the first cycle after reset. Reset mid-operation drops the in-flight operand and emits no result.
- States: IDLE, SCAN, DONE.
- IDLE:
  - ready_o=1.
  - Accept when valid_i && ready_o: register mant_i, exp_i; lz=0; byte index=0; go to SCAN.
- SCAN, one cycle per step:
  - If the top byte of the working mantissa is zero and byte index < NB-1: shift left 8, lz+=8, index+=1, stay in SCAN.
  - Otherwise, count the leading zeros c (0..8) of the top byte with the sub-module. Shift left by c (c<8), set lz+=c, then go to DONE.
  - c=8 occurs only at the last byte, i.e. the input was all zeros: zero_o=1, lz=XLEN, mant_o=0.
  - In DONE: exp_o=exp_i-lz (wraps), except when zero_o=1, where exp_o=exp_i. uf_o=(lz>=exp_i)&&!zero_o.
- Latency: k = min(leading zero bytes, NB-1). valid_o rises k+1 cycles after the accept edge.
- DONE:
  - valid_o=1; all outputs are held stable while ready_i=0.
  - On valid_o && ready_i: valid_o=0 next cycle, go to IDLE.
- No same-cycle accept in DONE: ready_o is low outside IDLE, so throughput is one operand per (k+3) cycles minimum.
- valid_i is ignored while ready_o=0; it need not be held. Once a value is accepted, changes to mant_i/exp_i have no effect.
- All outputs are registered. There is no combinational path from valid_i or ready_i to any output except ready_o, which decodes state only.

Decomposition:
- Shared package: state enum (IDLE/SCAN/DONE), BYTE_W=8 constant, and the LZ_W/NB derivation function.
- One sub-module: lz8_count, a combinational 8-bit leading-zero counter. Input 8 bits; outputs count 0..8 (4 bits) and all_zero. It is instantiated once on the top byte of the working register.

Test Plan:
- XLEN=32, EXP_W=10. mant_i=0x8000_0000, exp_i=100 → valid_o 1 cycle after accept; mant_o=0x8000_0000, lz_o=0, exp_o=100, zero_o=0, uf_o=0.
- mant_i=0x0000_1234, exp_i=100 → latency 3; mant_o=0x91A0_0000, lz_o=19, exp_o=81, uf_o=0.
- mant_i=0, exp_i=50 → latency 4; zero_o=1, lz_o=32, mant_o=0, exp_o=50, uf_o=0.
- mant_i=0x0000_0001, exp_i=20 → latency 4; mant_o=0x8000_0000, lz_o=31, exp_o=1013, uf_o=1.
- Case 2 with ready_i=0 for 5 cycles after valid_o, and valid_i pulsed with new data meanwhile → outputs stable, ready_o=0, the new data is not captured. On the ready_i handshake, ready_o=1 the next cycle.
- Assert rst on the second SCAN cycle of case 2 → next cycle valid_o=0, all outputs 0, ready_o=1. No result is ever emitted for that operand. A subsequent case-1 operand completes correctly.
